// File: rtl/uart_rx_fifo.sv
// Receive buffer behind UartRx: one-shot ack capture into a circular FIFO.
// Show-ahead read port with occupancy count and sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_ack_o,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  input  logic                  clear_overflow_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RELEASE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ack_q;
  logic                  ovf_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf_set;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign rx_ack_o   = ack_q;
  assign overflow_o = ovf_q;
  assign data_o     = empty_o ? '0 : mem[rd_ptr];
  assign rd_en      = read_i && !empty_o;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_ready_i && !full_o) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is only looked at in IDLE; RELEASE lets the ack fall first
  always_comb begin
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    if (state_q == IDLE && rx_ready_i) begin
      wr_en   = !full_o;
      ovf_set = full_o;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ack_q <= wr_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
      // a new overflow beats a simultaneous clear
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clear_overflow_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= rx_data_i;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: UartRx-style ready/ack source and a byte scoreboard.
// Uses a depth-4 FIFO so full, overflow and wrap cases are reachable quickly.
module tb_uart_rx_fifo;

  localparam int DL = 2;
  localparam int DW = 8;

  logic          clock_i = 0;
  logic          reset_i = 1;
  logic [DW-1:0] rx_data_i = '0;
  logic          rx_ready_i = 0;
  logic          rx_ack_o;
  logic          read_i = 0;
  logic [DW-1:0] data_o;
  logic          empty_o;
  logic          full_o;
  logic [DL:0]   count_o;
  logic          overflow_o;
  logic          clear_overflow_i = 0;

  int checks = 0;
  int failures = 0;
  int acks = 0;
  logic [7:0] sb [$];

  uart_rx_fifo #(.DEPTH_LOG2(DL), .DATA_WIDTH(DW)) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .rx_data_i(rx_data_i),
    .rx_ready_i(rx_ready_i),
    .rx_ack_o(rx_ack_o),
    .read_i(read_i),
    .data_o(data_o),
    .empty_o(empty_o),
    .full_o(full_o),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .clear_overflow_i(clear_overflow_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic apply_reset();
    reset_i = 1;
    rx_ready_i = 0;
    read_i = 0;
    clear_overflow_i = 0;
    sb.delete();
    tick();
    tick();
    reset_i = 0;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // present a byte like UartRx: hold ready until one ack pulse is seen
  task automatic send_byte(input logic [7:0] b, input string name);
    logic got;
    got = 0;
    rx_data_i = b;
    rx_ready_i = 1;
    sb.push_back(b);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rx_ack_o) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_ack_timeout got=0 exp=1", name);
      rx_ready_i = 0;
    end else begin
      acks++;
      tick();
      checks++;
      if (rx_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_ack_width got=%b exp=0", name, rx_ack_o);
      end
      rx_ready_i = 0;
    end
  endtask

  task automatic read_check(input string name);
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty got=%0h exp=none", name, data_o);
    end else begin
      exp = sb.pop_front();
      if (data_o !== exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", name, data_o, exp);
      end
      read_i = 1;
      tick();
      read_i = 0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_ack", 32'(rx_ack_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_data", 32'(data_o), 0);
  endtask

  task automatic test_single();
    apply_reset();
    send_byte(8'h55, "single");
    chk("single_count", 32'(count_o), 1);
    chk("single_empty", 32'(empty_o), 0);
    read_check("single_data");
    chk("single_empty_after", 32'(empty_o), 1);
    chk("single_data_after", 32'(data_o), 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    acks = 0;
    send_byte(8'h55, "b2b0");
    send_byte(8'hAA, "b2b1");
    send_byte(8'hCC, "b2b2");
    chk("b2b_acks", 32'(acks), 3);
    chk("b2b_count", 32'(count_o), 3);
    for (int i = 0; i < 3; i++) read_check("b2b_read");
    chk("b2b_empty", 32'(empty_o), 1);
  endtask

  task automatic test_overflow();
    int extra;
    logic got;
    apply_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), "ovf_fill");
    chk("ovf_full", 32'(full_o), 1);
    chk("ovf_count", 32'(count_o), 4);
    rx_data_i = 8'h05;
    rx_ready_i = 1;
    sb.push_back(8'h05);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rx_ack_o) extra++;
    end
    chk("ovf_no_ack", 32'(extra), 0);
    chk("ovf_flag", 32'(overflow_o), 1);
    chk("ovf_count_held", 32'(count_o), 4);
    clear_overflow_i = 1;
    tick();
    clear_overflow_i = 0;
    chk("ovf_set_beats_clear", 32'(overflow_o), 1);
    read_check("ovf_read0");
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rx_ack_o) got = 1;
      else tick();
    end
    chk("ovf_late_ack", 32'(got), 1);
    chk("ovf_count_refill", 32'(count_o), 4);
    tick();
    rx_ready_i = 0;
    tick();
    clear_overflow_i = 1;
    tick();
    clear_overflow_i = 0;
    chk("ovf_cleared", 32'(overflow_o), 0);
    for (int i = 0; i < 4; i++) read_check("ovf_drain");
    chk("ovf_empty", 32'(empty_o), 1);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h10 + 8'(i), "wrap_send");
      checks++;
      if (count_o > 4) begin
        failures++;
        $display("FAIL wrap_count_bound got=%0d exp<=4", count_o);
      end
      if (i >= 1) read_check("wrap_read");
    end
    read_check("wrap_last");
    chk("wrap_empty", 32'(empty_o), 1);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    send_byte(8'hA0, "sim0");
    send_byte(8'hA1, "sim1");
    tick();
    chk("sim_head0", 32'(data_o), 32'(sb.pop_front()));
    rx_data_i = 8'hA2;
    rx_ready_i = 1;
    sb.push_back(8'hA2);
    read_i = 1;
    tick();
    read_i = 0;
    chk("sim_ack", 32'(rx_ack_o), 1);
    chk("sim_count", 32'(count_o), 2);
    tick();
    rx_ready_i = 0;
    read_check("sim_read1");
    read_check("sim_read2");
    read_i = 1;
    tick();
    read_i = 0;
    chk("sim_empty_read_count", 32'(count_o), 0);
    chk("sim_empty_read_data", 32'(data_o), 0);
    rx_data_i = 8'hB5;
    rx_ready_i = 1;
    sb.push_back(8'hB5);
    read_i = 1;
    tick();
    read_i = 0;
    chk("sim_wr_empty_count", 32'(count_o), 1);
    tick();
    rx_ready_i = 0;
    read_check("sim_wr_empty_data");
  endtask

  task automatic test_reset_mid();
    logic got;
    apply_reset();
    send_byte(8'h11, "mid0");
    send_byte(8'h22, "mid1");
    tick();
    rx_data_i = 8'h33;
    rx_ready_i = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (rx_ack_o) got = 1;
    end
    chk("mid_ack_seen", 32'(got), 1);
    chk("mid_count3", 32'(count_o), 3);
    reset_i = 1;
    rx_ready_i = 0;
    sb.delete();
    #1;
    chk("mid_ack_drop", 32'(rx_ack_o), 0);
    chk("mid_count0", 32'(count_o), 0);
    chk("mid_empty", 32'(empty_o), 1);
    tick();
    reset_i = 0;
    tick();
    send_byte(8'h3C, "mid_after");
    read_check("mid_after_data");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
